// File: rtl/pattern_tx_if.sv
// Serial pattern transmitter control/status bundle.
interface pattern_tx_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DIV_W = 8
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [DIV_W-1:0] bit_div;
  logic             o;
  logic             o_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, bit_div,
    input  o, o_valid, busy, done
  );

  modport slave (
    input  start, repeat_cnt, bit_div,
    output o, o_valid, busy, done
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial transmitter: sends PATTERN MSB first, repeated back-to-back, at a divided bit rate.
// All outputs are registered from next-state values so they change on the accepting edge.
module pattern_tx #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1101,
  parameter int unsigned          CNT_W   = 4,
  parameter int unsigned          DIV_W   = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  pattern_tx_if.slave bus
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state,    state_nxt;
  logic [DIV_W-1:0] div_lat,  div_lat_nxt;
  logic [DIV_W-1:0] div_cnt,  div_cnt_nxt;
  logic [BIT_W-1:0] bit_idx,  bit_idx_nxt;
  logic [CNT_W-1:0] rep_left, rep_left_nxt;
  logic             o_nxt, o_valid_nxt, busy_nxt, done_nxt;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      div_lat     <= '0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      rep_left    <= '0;
      bus.o       <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_lat     <= div_lat_nxt;
      div_cnt     <= div_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      rep_left    <= rep_left_nxt;
      bus.o       <= o_nxt;
      bus.o_valid <= o_valid_nxt;
      bus.busy    <= busy_nxt;
      bus.done    <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    div_lat_nxt  = div_lat;
    div_cnt_nxt  = div_cnt;
    bit_idx_nxt  = bit_idx;
    rep_left_nxt = rep_left;

    case (state)
      IDLE: begin
        if (bus.start) begin
          div_lat_nxt  = bus.bit_div;
          rep_left_nxt = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
          bit_idx_nxt  = BIT_W'(PAT_W - 1);
          div_cnt_nxt  = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (div_cnt == div_lat) begin
          div_cnt_nxt = '0;
          if (bit_idx != '0) begin
            bit_idx_nxt = bit_idx - BIT_W'(1);
          end else if (rep_left > CNT_W'(1)) begin
            rep_left_nxt = rep_left - CNT_W'(1);
            bit_idx_nxt  = BIT_W'(PAT_W - 1);
          end else begin
            state_nxt = DONE;
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt    = IDLE;
        div_lat_nxt  = '0;
        div_cnt_nxt  = '0;
        bit_idx_nxt  = '0;
        rep_left_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    o_valid_nxt = (state_nxt == SEND);
    o_nxt       = o_valid_nxt & PATTERN[bit_idx_nxt];
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx against a cycle-list reference model.
module tb_pattern_tx;

  localparam int unsigned PAT_W = 4;
  localparam logic [3:0]  PAT   = 4'b1101;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  pattern_tx_if #(.CNT_W(4), .DIV_W(8)) bus ();

  pattern_tx #(
    .PAT_W(4), .PATTERN(4'b1101), .CNT_W(4), .DIV_W(8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int cyc, input logic [3:0] exp);
    logic [3:0] got;
    got = {bus.o, bus.o_valid, bus.busy, bus.done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got{o,valid,busy,done}=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  // Starts a transmission in the current idle cycle and checks every cycle through
  // the following idle cycle. Optional mid-run config change and start pokes.
  task automatic send_check(input string name, input int reps, input int div,
                            input bit chg, input int rep2, input int div2, input bit poke);
    int eff, n, idx;
    bus.start      = 1'b1;
    bus.repeat_cnt = 4'(reps);
    bus.bit_div    = 8'(div);
    tick();
    bus.start = 1'b0;
    if (chg) begin
      bus.repeat_cnt = 4'(rep2);
      bus.bit_div    = 8'(div2);
    end
    eff = (reps == 0) ? 1 : reps;
    n   = PAT_W * eff * (div + 1);
    for (int i = 0; i < n; i++) begin
      idx = PAT_W - 1 - ((i / (div + 1)) % PAT_W);
      expect_out(name, i, {PAT[idx], 1'b1, 1'b1, 1'b0});
      bus.start = poke && (i == 1);
      tick();
    end
    expect_out({name, "_done"}, n, 4'b0011);
    bus.start = poke;
    tick();
    bus.start = 1'b0;
    expect_out({name, "_idle"}, n + 1, 4'b0000);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("reset_hold", i, 4'b0000);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("reset_idle", i, 4'b0000);
    end
  endtask

  task automatic test_single();
    send_check("single", 1, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_repeats_rate();
    send_check("rep2_div2", 2, 2, 1'b0, 0, 0, 1'b0);
    send_check("rep0", 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    send_check("busy_poke", 1, 0, 1'b0, 0, 0, 1'b1);
    send_check("after_done", 1, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_config_change();
    send_check("cfg_change", 3, 0, 1'b1, 1, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.start      = 1'b1;
    bus.repeat_cnt = 4'd4;
    bus.bit_div    = 8'd0;
    tick();
    bus.start = 1'b0;
    expect_out("mid_bit0", 0, 4'b1110);
    tick();
    expect_out("mid_bit1", 1, 4'b1110);
    tick();
    expect_out("mid_bit2", 2, 4'b0110);
    n_rst = 1'b0;
    #1;
    expect_out("mid_async", 0, 4'b0000);
    tick();
    expect_out("mid_held", 1, 4'b0000);
    n_rst = 1'b1;
    tick();
    expect_out("mid_release", 2, 4'b0000);
    tick();
    expect_out("mid_idle", 3, 4'b0000);
    send_check("mid_fresh", 1, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int r, d;
    bit c, p;
    for (int t = 0; t < 12; t++) begin
      r = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      c = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      send_check("random", r, d, c, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), p);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    n_rst          = 1'b0;
    bus.start      = 1'b0;
    bus.repeat_cnt = '0;
    bus.bit_div    = '0;
    test_reset();
    test_single();
    test_repeats_rate();
    test_start_while_busy();
    test_config_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial bit-stream transmitter; the transmit end of the single-bit serial sequence link whose receive end is the 4-bit Moore pattern detector.
- On a start request it emits a fixed PAT_W-bit pattern, MSB first (default 1101), a programmable number of times back-to-back, at a programmable bit rate.
- Produces clean, registered stimulus for detector-side logic and links; completion reported by a one-cycle done pulse.

Parameters:
- PAT_W, 4, pattern length in bits (>=2)
- PATTERN, 4'b1101, pattern transmitted MSB first
- CNT_W, 4, width of repeat count
- DIV_W, 8, width of bit-period divider

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  transmit request; sampled only in IDLE
- repeat_cnt  input  CNT_W  number of pattern repetitions; 0 treated as 1
- bit_div  input  DIV_W  clock cycles per bit minus 1
- o  output  1  serial data out
- o_valid  output  1  high while o carries a pattern bit
- busy  output  1  high from the cycle after accepted start through the DONE cycle
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock clk, reset n_rst: asynchronous, active-low.
- Reset: state IDLE; o=0, o_valid=0, busy=0, done=0; all counters and latched config cleared.
- Reset mid-transmission aborts immediately to the reset values. No resume.
- All outputs are registered and depend on state/counters only (Moore). No combinational path from start to any output.
- States: IDLE, SEND, DONE.
- IDLE:
  - o=0, o_valid=0, busy=0.
  - On start=1 at edge k: latch bit_div into div_lat; rep_left = max(repeat_cnt,1); bit_idx = PAT_W-1; div_cnt = 0; go to SEND.
- SEND, first cycle (edge k+1): o = PATTERN[PAT_W-1], o_valid=1, busy=1.
- SEND, bit timing:
  - Each bit is held div_lat+1 cycles. div_cnt counts 0..div_lat.
  - When div_cnt == div_lat: div_cnt -> 0 and advance to the next bit.
- SEND, bit advance:
  - If bit_idx > 0: bit_idx decrements.
  - Else if rep_left > 1: rep_left decrements, bit_idx -> PAT_W-1. The next repetition follows with no gap.
  - Else: go to DONE.
- DONE:
  - Exactly one cycle: done=1, busy=1, o=0, o_valid=0.
  - Then IDLE with busy=0.
  - A new start is accepted in the IDLE cycle immediately after DONE, giving a minimum turnaround of one idle cycle.
- start is ignored while busy=1. Changes to repeat_cnt or bit_div after acceptance have no effect on the current transmission.
- Total SEND duration = PAT_W * max(repeat_cnt,1) * (bit_div+1) cycles.
  - Max reps = 2^CNT_W - 1. Counters are sized so that no wrap occurs at maximum settings.
- Arithmetic: all counters are unsigned. Decrements never underflow because of the guards above.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles, then release -> o=0, o_valid=0, busy=0, done=0 on every cycle; remains idle without start.
- Single pattern: repeat_cnt=1, bit_div=0, start pulse at edge k -> o=1,1,0,1 on cycles k+1..k+4 with o_valid=1; done=1 only on k+5; busy=0 at k+6. A detector fed o asserts once.
- Repeats plus rate: repeat_cnt=2, bit_div=2 -> o = 111 111 000 111 111 111 000 111 (24 cycles, o_valid=1 throughout); done on cycle 25. repeat_cnt=0 with bit_div=0 yields exactly 4 bits, same as repeat_cnt=1.
- Start while busy: start asserted on cycles k+2 and k+5 of a repeat_cnt=1, bit_div=0 run (k+5 is the DONE cycle) -> both ignored; exactly 4 bits sent. A start at k+6 (IDLE) is accepted, and its first bit appears at k+7.
- Config change mid-run: after acceptance with bit_div=0, repeat_cnt=3, change inputs to bit_div=5, repeat_cnt=1 -> output is still 12 single-cycle bits 110111011101.
- Reset mid-operation: n_rst=0 during the 3rd bit of a repeat_cnt=4 run -> the same cycle gives o=0, o_valid=0, busy=0; no done pulse. A fresh start after release transmits 1101 from the MSB.
